serial_add_sub: RTL and testbench

//   Parametrised bit-serial adder/subtractor built around a single 1-bit full-adder cell.
//   A start pulse launches a WIDTH-cycle operation, processing one bit per clock, LSB first.
//   The carry is held in a flip-flop between bits.
//   It is the area-cheap sequential successor to the combinational full adder.
//   It serves as the arithmetic unit for the lab datapath when gate count matters more than latency.

---
 rtl/serial_add_sub_pkg.sv | 18 +
 rtl/serial_add_sub_if.sv | 26 ++
 rtl/serial_add_sub_full_adder_bit.sv | 11 +
 rtl/serial_add_sub.sv | 104 ++++++++++
 tb/tb_serial_add_sub.sv | 249 ++++++++++++++++++++++++
 5 files changed

// File: rtl/serial_add_sub_pkg.sv
// Shared definitions for the bit-serial adder family: FSM state encodings and
// the legal operand-width range.
package serial_add_sub_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam int WIDTH_MIN = 2;
    localparam int WIDTH_MAX = 32;

    function automatic bit width_ok(input int w);
        return (w >= WIDTH_MIN) && (w <= WIDTH_MAX);
    endfunction

endpackage

// File: rtl/serial_add_sub_if.sv
// Request/result bundle of the bit-serial adder; master launches operations,
// slave (the adder) returns status and the captured result.
interface serial_add_sub_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic             sub;
    logic             cin;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;

    modport master (
        output start, sub, cin, a, b,
        input  busy, done, sum, cout, ovf
    );

    modport slave (
        input  start, sub, cin, a, b,
        output busy, done, sum, cout, ovf
    );
endinterface

// File: rtl/serial_add_sub_full_adder_bit.sv
// Single-bit combinational full adder; the only arithmetic cell of the serial adder.
module full_adder_bit (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);
    assign sum  = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));
endmodule

// File: rtl/serial_add_sub.sv
// Bit-serial adder/subtractor: one full-adder cell, one bit per clock LSB first,
// carry held in a flip-flop between bits.
module serial_add_sub
    import serial_add_sub_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    serial_add_sub_if.slave  bus
);
    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] CNT_MSB  = CNT_W'(WIDTH - 2);

    if (!width_ok(WIDTH)) begin : g_width_chk
        $error("serial_add_sub: WIDTH out of range 2..32");
    end

    state_t           state, state_nxt;
    logic             accept;
    logic [CNT_W-1:0] count;
    logic [WIDTH-1:0] op_a, op_b, res;
    logic [WIDTH-1:0] sum_q;
    logic             carry, carry_msb, cout_q, ovf_q;
    logic             fa_sum, fa_cout;

    full_adder_bit u_fa (
        .a    (op_a[0]),
        .b    (op_b[0]),
        .cin  (carry),
        .sum  (fa_sum),
        .cout (fa_cout)
    );

    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (bus.start) begin
                    state_nxt = ST_RUN;
                    accept    = 1'b1;
                end
            end
            ST_RUN: begin
                if (count == CNT_LAST) state_nxt = ST_DONE;
            end
            ST_DONE: begin
                if (bus.start) begin
                    state_nxt = ST_RUN;
                    accept    = 1'b1;
                end else begin
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    // Subtraction is a + ~b + ~borrow, so the inversion happens once at capture.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_a      <= '0;
            op_b      <= '0;
            res       <= '0;
            count     <= '0;
            carry     <= 1'b0;
            carry_msb <= 1'b0;
            sum_q     <= '0;
            cout_q    <= 1'b0;
            ovf_q     <= 1'b0;
        end else if (accept) begin
            op_a  <= bus.a;
            op_b  <= bus.sub ? ~bus.b : bus.b;
            carry <= bus.cin ^ bus.sub;
            count <= '0;
        end else if (state == ST_RUN) begin
            res   <= {fa_sum, res[WIDTH-1:1]};
            op_a  <= op_a >> 1;
            op_b  <= op_b >> 1;
            carry <= fa_cout;
            count <= count + CNT_W'(1);
            if (count == CNT_MSB) carry_msb <= fa_cout;
            if (count == CNT_LAST) begin
                sum_q  <= {fa_sum, res[WIDTH-1:1]};
                cout_q <= fa_cout;
                ovf_q  <= carry_msb ^ fa_cout;
            end
        end
    end

    assign bus.busy = (state == ST_RUN);
    assign bus.done = (state == ST_DONE);
    assign bus.sum  = sum_q;
    assign bus.cout = cout_q;
    assign bus.ovf  = ovf_q;

endmodule

// File: tb/tb_serial_add_sub.sv
// Bench for serial_add_sub at WIDTH=8 (directed + random) and WIDTH=4 (exhaustive),
// checked every cycle against an arithmetic model of a +/- b +/- cin.
module tb_serial_add_sub;

    typedef struct {
        longint due;
        longint s;
        bit     co;
        bit     ov;
    } exp_t;

    logic   clk = 1'b0;
    logic   rst_n = 1'b0;
    longint cyc = 0;
    int     checks = 0;
    int     fails = 0;
    exp_t   q8[$];
    exp_t   q4[$];
    longint h8_s = 0, h4_s = 0;
    bit     h8_co = 0, h8_ov = 0, h4_co = 0, h4_ov = 0;

    serial_add_sub_if #(.WIDTH(8)) if8 ();
    serial_add_sub_if #(.WIDTH(4)) if4 ();

    serial_add_sub #(.WIDTH(8)) dut8 (.clk(clk), .rst_n(rst_n), .bus(if8));
    serial_add_sub #(.WIDTH(4)) dut4 (.clk(clk), .rst_n(rst_n), .bus(if4));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic void chk(input string nm, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", nm, act, exp, $time);
        end
    endfunction

    // Reference: exact unsigned and signed results of a+b+cin or a-b-cin.
    function automatic exp_t model(input int w, input longint a, input longint b,
                                   input bit cin, input bit sub, input longint due);
        exp_t   e;
        longint half = 64'(1) << (w - 1);
        longint full = 64'(1) << w;
        longint sa = (a >= half) ? a - full : a;
        longint sb = (b >= half) ? b - full : b;
        longint eu, es;
        if (sub) begin
            eu   = a - b - longint'(cin);
            es   = sa - sb - longint'(cin);
            e.co = (a >= b + longint'(cin));
        end else begin
            eu   = a + b + longint'(cin);
            es   = sa + sb + longint'(cin);
            e.co = (eu >= full);
        end
        e.s   = eu & (full - 1);
        e.ov  = (es < -half) || (es >= half);
        e.due = due;
        return e;
    endfunction

    always @(negedge clk) begin
        if (!rst_n) begin
            q8.delete();
            h8_s = 0; h8_co = 0; h8_ov = 0;
        end else begin
            bit busy_e, done_e;
            busy_e = (q8.size() > 0) && (cyc >= q8[0].due - 8) && (cyc < q8[0].due);
            done_e = (q8.size() > 0) && (q8[0].due == cyc);
            chk("busy8", if8.busy, busy_e);
            chk("done8", if8.done, done_e);
            chk("excl8", if8.busy & if8.done, 0);
            if (done_e) begin
                h8_s = q8[0].s; h8_co = q8[0].co; h8_ov = q8[0].ov;
                void'(q8.pop_front());
            end
            chk("sum8", if8.sum, h8_s);
            chk("cout8", if8.cout, h8_co);
            chk("ovf8", if8.ovf, h8_ov);
        end
    end

    always @(negedge clk) begin
        if (!rst_n) begin
            q4.delete();
            h4_s = 0; h4_co = 0; h4_ov = 0;
        end else begin
            bit busy_e, done_e;
            busy_e = (q4.size() > 0) && (cyc >= q4[0].due - 4) && (cyc < q4[0].due);
            done_e = (q4.size() > 0) && (q4[0].due == cyc);
            chk("busy4", if4.busy, busy_e);
            chk("done4", if4.done, done_e);
            chk("excl4", if4.busy & if4.done, 0);
            if (done_e) begin
                h4_s = q4[0].s; h4_co = q4[0].co; h4_ov = q4[0].ov;
                void'(q4.pop_front());
            end
            chk("sum4", if4.sum, h4_s);
            chk("cout4", if4.cout, h4_co);
            chk("ovf4", if4.ovf, h4_ov);
        end
    end

    task automatic drive(input int w, input longint a, input longint b, input bit cin, input bit sub);
        if (w == 8) begin
            if8.a = a[7:0]; if8.b = b[7:0]; if8.cin = cin; if8.sub = sub;
        end else begin
            if4.a = a[3:0]; if4.b = b[3:0]; if4.cin = cin; if4.sub = sub;
        end
    endtask

    task automatic push(input int w, input longint a, input longint b, input bit cin, input bit sub);
        if (w == 8) q8.push_back(model(8, a, b, cin, sub, cyc + 8));
        else        q4.push_back(model(4, a, b, cin, sub, cyc + 4));
    endtask

    // Launch from mid-period; returns the index of the edge that sampled start.
    task automatic go(input int w, input longint a, input longint b, input bit cin, input bit sub,
                      output longint c);
        drive(w, a, b, cin, sub);
        if (w == 8) if8.start = 1'b1; else if4.start = 1'b1;
        @(posedge clk);
        #1;
        if (w == 8) if8.start = 1'b0; else if4.start = 1'b0;
        c = cyc;
        push(w, a, b, cin, sub);
        drive(w, longint'($urandom), longint'($urandom), 1'($urandom), 1'($urandom));
    endtask

    task automatic wait_done(input int w, output longint dcyc);
        dcyc = -1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if ((w == 8 && if8.done === 1'b1) || (w == 4 && if4.done === 1'b1)) begin
                dcyc = cyc;
                break;
            end
        end
        if (dcyc < 0) begin
            checks++;
            fails++;
            $display("FAIL done_timeout w=%0d actual=no_done expected=done t=%0t", w, $time);
        end
    endtask

    task automatic lit8(input string nm, input longint s, input bit co, input bit ov);
        chk({nm, "_sum"}, if8.sum, s);
        chk({nm, "_cout"}, if8.cout, co);
        chk({nm, "_ovf"}, if8.ovf, ov);
    endtask

    initial begin
        longint c, d;
        if8.start = 0; if8.sub = 0; if8.cin = 0; if8.a = 0; if8.b = 0;
        if4.start = 0; if4.sub = 0; if4.cin = 0; if4.a = 0; if4.b = 0;
        repeat (3) @(negedge clk);
        chk("rst_busy", if8.busy, 0);
        chk("rst_done", if8.done, 0);
        lit8("rst", 0, 0, 0);
        @(posedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);

        // Directed vectors with hand-computed results
        go(8, 'h0F, 'h01, 0, 0, c);
        wait_done(8, d);
        chk("lat_t1", d - c, 8);
        lit8("t1", 'h10, 0, 0);
        go(8, 'hFF, 'h01, 0, 0, c);  wait_done(8, d);  lit8("t2a", 'h00, 1, 0);
        go(8, 'h7F, 'h01, 0, 0, c);  wait_done(8, d);  lit8("t2b", 'h80, 0, 1);
        go(8, 'h05, 'h07, 0, 1, c);  wait_done(8, d);  lit8("t3a", 'hFE, 0, 0);
        go(8, 'h80, 'h01, 0, 1, c);  wait_done(8, d);  lit8("t3b", 'h7F, 1, 1);
        repeat (2) @(negedge clk);

        // Ignored starts during RUN, then start held through DONE
        go(8, 'h33, 'h44, 0, 0, c);
        repeat (3) @(negedge clk);
        if8.start = 1'b1;
        @(negedge clk);
        if8.start = 1'b0;
        @(negedge clk);
        if8.start = 1'b1;
        @(negedge clk);
        if8.start = 1'b0;
        repeat (2) @(negedge clk);
        drive(8, 'hA0, 'h70, 0, 0);
        if8.start = 1'b1;
        @(posedge clk);
        #1;
        chk("t4_done1", if8.done, 1);
        lit8("t4_op1", 'h77, 0, 0);
        @(posedge clk);
        #1;
        if8.start = 1'b0;
        push(8, 'hA0, 'h70, 0, 0);
        c = cyc;
        wait_done(8, d);
        chk("t4_lat2", d - c, 8);
        lit8("t4_op2", 'h10, 1, 0);

        // Asynchronous reset in the middle of an operation
        go(8, 'h5A, 'h3C, 1, 0, c);
        repeat (5) @(negedge clk);
        chk("t5_busy_before", if8.busy, 1);
        #1 rst_n = 1'b0;
        #1;
        chk("t5_busy", if8.busy, 0);
        chk("t5_done", if8.done, 0);
        lit8("t5", 0, 0, 0);
        @(negedge clk);
        @(posedge clk);
        #2 rst_n = 1'b1;
        repeat (12) @(negedge clk);
        go(8, 'h12, 'h34, 0, 0, c);
        wait_done(8, d);
        lit8("t5_after", 'h46, 0, 0);

        // Random WIDTH=8 traffic, mixing back-to-back and gapped launches
        for (int i = 0; i < 150; i++) begin
            go(8, longint'($urandom_range(0, 255)), longint'($urandom_range(0, 255)),
               1'($urandom), 1'($urandom), c);
            wait_done(8, d);
            if ($urandom_range(0, 2) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
        end

        // Exhaustive WIDTH=4, every operation launched in the previous DONE cycle
        for (int s = 0; s < 2; s++)
            for (int ci = 0; ci < 2; ci++)
                for (int a = 0; a < 16; a++)
                    for (int b = 0; b < 16; b++) begin
                        go(4, longint'(a), longint'(b), 1'(ci), 1'(s), c);
                        wait_done(4, d);
                    end

        repeat (4) @(negedge clk);
        chk("q8_drained", q8.size(), 0);
        chk("q4_drained", q4.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout actual=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
